// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one shared full-subtractor cell computes A - B - borrow_in
// LSB first, one bit per clock, with a registered borrow chain and a done pulse.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_borrow_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sd;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrowOut;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_sdNext;

  // The shared cell works on the low bits; the new difference bit enters at the MSB
  // so that after WIDTH shifts the result register holds the word in natural order.
  always_comb begin
    w_x      = r_sa[0];
    w_y      = r_sb[0];
    w_d      = w_x ^ w_y ^ r_br;
    w_bo     = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
    w_sdNext = r_sd >> 1;
    w_sdNext[WIDTH-1] = w_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sa        <= '0;
      r_sb        <= '0;
      r_sd        <= '0;
      r_br        <= 1'b0;
      r_cnt       <= '0;
      r_diff      <= '0;
      r_borrowOut <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_sa    <= i_a;
            r_sb    <= i_b;
            r_br    <= i_borrow_in;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sd  <= w_sdNext;
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_br  <= w_bo;
          r_cnt <= r_cnt + CW'(1);
          // Publish directly from the next-value path so the result lands on the last RUN edge.
          if (r_cnt == LAST_BIT) begin
            r_diff      <= w_sdNext;
            r_borrowOut <= w_bo;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy       = (r_state == RUN);
  assign o_done       = (r_state == DONE);
  assign o_diff       = r_diff;
  assign o_borrow_out = r_borrowOut;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl: an 8-bit instance for directed and
// random operations, plus a 1-bit instance swept exhaustively.
module tb_serial_subtractor_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  logic         start1 = 1'b0;
  logic [0:0]   a1 = '0;
  logic [0:0]   b1 = '0;
  logic         bin1 = 1'b0;
  logic         busy1;
  logic         done1;
  logic [0:0]   diff1;
  logic         bout1;

  serial_subtractor_ctrl #(.WIDTH(W)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_a          (a),
    .i_b          (b),
    .i_borrow_in  (bin),
    .o_busy       (busy),
    .o_done       (done),
    .o_diff       (diff),
    .o_borrow_out (bout)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start1),
    .i_a          (a1),
    .i_b          (b1),
    .i_borrow_in  (bin1),
    .o_busy       (busy1),
    .o_done       (done1),
    .o_diff       (diff1),
    .o_borrow_out (bout1)
  );

  int errors = 0;
  int checks = 0;
  logic [W:0] sbQ[$];
  logic [1:0] sbQ1[$];
  logic [W-1:0] lastDiff = '0;
  logic         lastBorrow = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Unsigned reference: the extra top bit of the widened difference is the final borrow.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - (W+1)'(c);
  endfunction

  always @(negedge clk) begin : monitor8
    logic [W:0] e;
    if (done === 1'b1) begin
      checkOutput("busyWithDone", 32'(busy), 32'd0);
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'd1, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("diff", 32'(diff), 32'(e[W-1:0]));
        checkOutput("borrowOut", 32'(bout), 32'(e[W]));
        lastDiff   = e[W-1:0];
        lastBorrow = e[W];
      end
    end
  end

  always @(negedge clk) begin : monitor1
    logic [1:0] e;
    if (done1 === 1'b1) begin
      checkOutput("busyWithDone1", 32'(busy1), 32'd0);
      if (sbQ1.size() == 0) begin
        checkOutput("unexpectedDone1", 32'd1, 32'd0);
      end else begin
        e = sbQ1.pop_front();
        checkOutput("diff1", 32'(diff1), 32'(e[0]));
        checkOutput("borrowOut1", 32'(bout1), 32'(e[1]));
      end
    end
  end

  // One operation on the 8-bit instance; optionally pokes start with junk operands
  // during RUN cycles 3 and 8 and checks that the previous result is still held.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                               input bit inject);
    int busyCount = 0;
    bit got = 0;
    @(negedge clk);
    a = x; b = y; bin = c; start = 1'b1;
    sbQ.push_back(model(x, y, c));
    for (int n = 0; n < W + 6 && !got; n++) begin
      @(negedge clk);
      start = inject && (n == 2 || n == 7);
      if (start) begin
        a = 8'hFF; b = 8'h00;
      end
      if (done === 1'b1) got = 1;
      else if (busy === 1'b1) busyCount++;
      if (inject && !got) begin
        checkOutput("holdDiff", 32'(diff), 32'(lastDiff));
        checkOutput("holdBorrow", 32'(bout), 32'(lastBorrow));
      end
    end
    start = 1'b0;
    checkOutput("doneSeen", 32'(got), 32'd1);
    checkOutput("busyCycles", 32'(busyCount), 32'(W));
  endtask

  task automatic applyStimulus1(input logic x, input logic y, input logic c);
    @(negedge clk);
    a1 = x; b1 = y; bin1 = c; start1 = 1'b1;
    sbQ1.push_back(2'({1'b0, x} - {1'b0, y} - {1'b0, c}));
    @(negedge clk);
    start1 = 1'b0;
    checkOutput("busy1", 32'(busy1), 32'd1);
    @(negedge clk);
    checkOutput("done1Latency", 32'(done1), 32'd1);
  endtask

  initial begin
    int doneAt[$];
    logic [W-1:0] rx;
    logic [W-1:0] ry;

    #1 rst_n = 1'b0;
    #10;
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstDiff", 32'(diff), 32'd0);
    checkOutput("rstBorrow", 32'(bout), 32'd0);
    checkOutput("rstBusy1", 32'(busy1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
    applyStimulus(8'h10, 8'h0F, 1'b1, 1'b1);
    applyStimulus(8'h00, 8'h01, 1'b0, 1'b0);

    // Abort an operation mid-flight with reset; no result may ever appear for it.
    @(negedge clk);
    a = 8'h33; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    checkOutput("midRstDiff", 32'(diff), 32'd0);
    checkOutput("midRstBorrow", 32'(bout), 32'd0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("doneInReset", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    lastDiff = '0;
    lastBorrow = 1'b0;
    repeat (12) @(negedge clk);
    applyStimulus(8'h80, 8'h01, 1'b0, 1'b0);

    // Start held high: acceptances every W+2 cycles, three within 30 edges.
    @(negedge clk);
    a = 8'hC3; b = 8'h5D; bin = 1'b1; start = 1'b1;
    repeat (3) sbQ.push_back(model(8'hC3, 8'h5D, 1'b1));
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneAt.push_back(i);
    end
    start = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("heldDoneCount", 32'(doneAt.size()), 32'd3);
    for (int k = 1; k < doneAt.size(); k++)
      checkOutput("heldSpacing", 32'(doneAt[k] - doneAt[k-1]), 32'(W + 2));

    repeat (1000) begin
      rx = W'($urandom);
      ry = W'($urandom);
      applyStimulus(rx, ry, 1'($urandom_range(0, 1)), 1'b0);
    end

    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      applyStimulus1(vv[2], vv[1], vv[0]);
    end

    repeat (4) @(negedge clk);
    checkOutput("queueEmpty", 32'(sbQ.size()), 32'd0);
    checkOutput("queueEmpty1", 32'(sbQ1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
